// File: rtl/dds_sweep_pkg.sv
// rtl/dds_sweep_pkg.sv - shared state encoding and default widths for the DDS frequency sweep sequencer
package dds_sweep_pkg;

   localparam int DEF_FTW_W    = 32;
   localparam int DEF_PT_W     = 12;
   localparam int DEF_DWELL_W  = 24;
   localparam int DEF_SETTLE_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      DWELL,
      STEP,
      DONE
   } state_t;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sweep_timer.sv
// rtl/sweep_timer.sv - loadable down-counter shared by the settle and dwell phases
module sweep_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expire
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   // Loaded values are always >= 1, so the count reads 1 on the final cycle of a phase.
   assign expire = (cnt_q <= W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - steps the DDS tuning word through N points with settle and dwell windows
// Optional DDS_SWEEP_LOOP_EN adds i_loop: a latched loop request restarts the sweep after each pass.
module dds_sweep_ctrl
   import dds_sweep_pkg::*;
#(
   parameter int FTW_W    = DEF_FTW_W,
   parameter int PT_W     = DEF_PT_W,
   parameter int DWELL_W  = DEF_DWELL_W,
   parameter int SETTLE_W = DEF_SETTLE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [FTW_W-1:0]    i_ftw_start,
   input  logic [FTW_W-1:0]    i_ftw_step,
   input  logic [PT_W-1:0]     i_num_points,
   input  logic [SETTLE_W-1:0] i_settle_cycles,
   input  logic [DWELL_W-1:0]  i_dwell_cycles,
`ifdef DDS_SWEEP_LOOP_EN
   input  logic                i_loop,
`endif
   output logic [FTW_W-1:0]    o_DDS_FTW,
   output logic [PT_W-1:0]     o_point_idx,
   output logic                o_meas_en,
   output logic                o_point_done,
   output logic                o_busy,
   output logic                o_done
);

   localparam int TMR_W = max_w(DWELL_W, SETTLE_W);

   state_t              state_q, state_d;
   logic [FTW_W-1:0]    ftw_q;
   logic [FTW_W-1:0]    step_q;
   logic [PT_W-1:0]     idx_q;
   logic [PT_W-1:0]     n_q;
   logic [SETTLE_W-1:0] settle_q;
   logic [TMR_W-1:0]    dwell_q;
`ifdef DDS_SWEEP_LOOP_EN
   logic [FTW_W-1:0]    start_q;
   logic                loop_q;
`endif

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_value;
   logic             tmr_expire;
   logic [TMR_W-1:0] dwell_in_eff;
   logic             last_pt;

   // A zero dwell still produces a one-cycle measurement window.
   assign dwell_in_eff = (i_dwell_cycles == '0) ? TMR_W'(1) : TMR_W'(i_dwell_cycles);
   assign last_pt      = (idx_q == n_q - PT_W'(1));

   sweep_timer #(.W(TMR_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .value  (tmr_value),
      .expire (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      tmr_load  = 1'b0;
      tmr_value = '0;
      if (i_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  if (i_num_points == '0) begin
                     state_d = DONE;
                  end else if (i_settle_cycles == '0) begin
                     state_d   = DWELL;
                     tmr_load  = 1'b1;
                     tmr_value = dwell_in_eff;
                  end else begin
                     state_d   = SETTLE;
                     tmr_load  = 1'b1;
                     tmr_value = TMR_W'(i_settle_cycles);
                  end
               end
            end
            SETTLE: begin
               if (tmr_expire) begin
                  state_d   = DWELL;
                  tmr_load  = 1'b1;
                  tmr_value = dwell_q;
               end
            end
            DWELL: begin
               if (tmr_expire) begin
                  state_d = last_pt ? DONE : STEP;
               end
            end
            STEP: begin
               // Zero settle skips the SETTLE state entirely to keep the per-point period exact.
               if (settle_q == '0) begin
                  state_d   = DWELL;
                  tmr_load  = 1'b1;
                  tmr_value = dwell_q;
               end else begin
                  state_d   = SETTLE;
                  tmr_load  = 1'b1;
                  tmr_value = TMR_W'(settle_q);
               end
            end
            DONE: begin
               state_d = IDLE;
`ifdef DDS_SWEEP_LOOP_EN
               if (loop_q) begin
                  if (n_q == '0) begin
                     state_d = DONE;
                  end else if (settle_q == '0) begin
                     state_d   = DWELL;
                     tmr_load  = 1'b1;
                     tmr_value = dwell_q;
                  end else begin
                     state_d   = SETTLE;
                     tmr_load  = 1'b1;
                     tmr_value = TMR_W'(settle_q);
                  end
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         ftw_q    <= '0;
         step_q   <= '0;
         idx_q    <= '0;
         n_q      <= '0;
         settle_q <= '0;
         dwell_q  <= '0;
`ifdef DDS_SWEEP_LOOP_EN
         start_q  <= '0;
         loop_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (!i_abort) begin
            case (state_q)
               IDLE: begin
                  if (i_start) begin
                     step_q   <= i_ftw_step;
                     n_q      <= i_num_points;
                     settle_q <= i_settle_cycles;
                     dwell_q  <= dwell_in_eff;
`ifdef DDS_SWEEP_LOOP_EN
                     start_q  <= i_ftw_start;
                     loop_q   <= i_loop;
`endif
                     if (i_num_points != '0) begin
                        ftw_q <= i_ftw_start;
                        idx_q <= '0;
                     end
                  end
               end
               STEP: begin
                  ftw_q <= ftw_q + step_q;
                  idx_q <= idx_q + PT_W'(1);
               end
`ifdef DDS_SWEEP_LOOP_EN
               DONE: begin
                  if (loop_q && (n_q != '0)) begin
                     ftw_q <= start_q;
                     idx_q <= '0;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign o_DDS_FTW    = ftw_q;
   assign o_point_idx  = idx_q;
   assign o_meas_en    = (state_q == DWELL);
   assign o_point_done = (state_q == DWELL) && tmr_expire;
   assign o_busy       = (state_q != IDLE);
   assign o_done       = (state_q == DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed vector bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start, i_abort;
   logic [31:0] i_ftw_start, i_ftw_step;
   logic [11:0] i_num_points;
   logic [15:0] i_settle_cycles;
   logic [23:0] i_dwell_cycles;
`ifdef DDS_SWEEP_LOOP_EN
   logic        i_loop;
`endif
   logic [31:0] o_DDS_FTW;
   logic [11:0] o_point_idx;
   logic        o_meas_en, o_point_done, o_busy, o_done;

   always #5 clk = ~clk;

   dds_sweep_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .i_start         (i_start),
      .i_abort         (i_abort),
      .i_ftw_start     (i_ftw_start),
      .i_ftw_step      (i_ftw_step),
      .i_num_points    (i_num_points),
      .i_settle_cycles (i_settle_cycles),
      .i_dwell_cycles  (i_dwell_cycles),
`ifdef DDS_SWEEP_LOOP_EN
      .i_loop          (i_loop),
`endif
      .o_DDS_FTW       (o_DDS_FTW),
      .o_point_idx     (o_point_idx),
      .o_meas_en       (o_meas_en),
      .o_point_done    (o_point_done),
      .o_busy          (o_busy),
      .o_done          (o_done)
   );

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] start;
      logic [31:0] step;
      logic [11:0] n;
      logic [15:0] settle;
      logic [23:0] dwell;
      int          exp_done;
      int          exp_pd;
      int          exp_meas;
      int          exp_first_meas;
      logic [31:0] exp_ftw;
      logic [11:0] exp_idx;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [31:0] s, input logic [31:0] st, input logic [11:0] n,
                          input logic [15:0] se, input logic [23:0] dw);
      i_ftw_start     = s;
      i_ftw_step      = st;
      i_num_points    = n;
      i_settle_cycles = se;
      i_dwell_cycles  = dw;
   endtask

   task automatic scramble_cfg();
      i_ftw_start     = $urandom;
      i_ftw_step      = $urandom;
      i_num_points    = 12'($urandom_range(1, 4095));
      i_settle_cycles = 16'($urandom_range(0, 7));
      i_dwell_cycles  = 24'($urandom_range(0, 7));
   endtask

   task automatic run_vec(input vec_t v, input int vi);
      int          done_at, pd, meas, first, busy, post_busy;
      logic [31:0] exp_f;
      logic [31:0] ftw_at_done;
      logic [11:0] idx_at_done;
      done_at = -1; pd = 0; meas = 0; first = 0; busy = 0; post_busy = 0;
      ftw_at_done = '0; idx_at_done = '0;
      set_cfg(v.start, v.step, v.n, v.settle, v.dwell);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      scramble_cfg();
      for (int c = 1; c <= 200; c++) begin
         if (o_meas_en) begin
            meas++;
            if (first == 0) first = c;
         end
         if (o_point_done) begin
            exp_f = v.start + v.step * 32'(pd);
            chk($sformatf("v%0d_pt%0d_ftw", vi, pd), o_DDS_FTW, exp_f);
            pd++;
         end
         if (o_busy) busy++;
         if (o_done) begin
            done_at     = c;
            ftw_at_done = o_DDS_FTW;
            idx_at_done = o_point_idx;
            break;
         end
         i_start = (c == 2 && v.exp_done > 3);
         tick();
      end
      i_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (o_busy || o_done) post_busy++;
      end
      chk($sformatf("v%0d_done_cycle", vi), done_at, v.exp_done);
      chk($sformatf("v%0d_point_done_cnt", vi), pd, v.exp_pd);
      chk($sformatf("v%0d_meas_cycles", vi), meas, v.exp_meas);
      chk($sformatf("v%0d_first_meas", vi), first, v.exp_first_meas);
      chk($sformatf("v%0d_busy_cycles", vi), busy, v.exp_done);
      chk($sformatf("v%0d_final_ftw", vi), ftw_at_done, v.exp_ftw);
      chk($sformatf("v%0d_final_idx", vi), idx_at_done, v.exp_idx);
      chk($sformatf("v%0d_idle_after", vi), post_busy, 0);
   endtask

   initial begin
      int cnt;
      rst = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
      i_loop = 1'b0;
`endif
      set_cfg('0, '0, '0, '0, '0);

      vecs[0] = '{32'h0100_0000, 32'h0010_0000, 12'd4, 16'd3, 24'd5, 36, 4, 20, 4, 32'h0130_0000, 12'd3};
      vecs[1] = '{32'hAAAA_0000, 32'h0000_0001, 12'd0, 16'd3, 24'd5,  1, 0,  0, 0, 32'h0130_0000, 12'd3};
      vecs[2] = '{32'h1234_5678, 32'h0000_1000, 12'd1, 16'd0, 24'd0,  2, 1,  1, 1, 32'h1234_5678, 12'd0};
      vecs[3] = '{32'hFFFF_FFF0, 32'h0000_0020, 12'd2, 16'd1, 24'd2,  8, 2,  4, 2, 32'h0000_0010, 12'd1};
      vecs[4] = '{32'h0000_0100, 32'h0000_0100, 12'd3, 16'd2, 24'd1, 12, 3,  3, 3, 32'h0000_0300, 12'd2};
      vecs[5] = '{32'h0000_0005, 32'h8000_0000, 12'd2, 16'd0, 24'd3,  8, 2,  6, 1, 32'h8000_0005, 12'd1};

      #12;
      chk("rst_ftw", o_DDS_FTW, 0);
      chk("rst_idx", o_point_idx, 0);
      chk("rst_meas_en", o_meas_en, 0);
      chk("rst_point_done", o_point_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Abort in the dwell window of point 2 (cycles 22..26 of the basic sweep).
      set_cfg(32'h0100_0000, 32'h0010_0000, 12'd4, 16'd3, 24'd5);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 1; c < 23; c++) tick();
      chk("abort_pre_meas_en", o_meas_en, 1);
      chk("abort_pre_idx", o_point_idx, 2);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("abort_busy", o_busy, 0);
      chk("abort_meas_en", o_meas_en, 0);
      chk("abort_point_done", o_point_done, 0);
      chk("abort_ftw_hold", o_DDS_FTW, 32'h0120_0000);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (o_done || o_point_done || o_busy) cnt++;
         tick();
      end
      chk("abort_no_pulses", cnt, 0);

      // Start and abort together in IDLE: abort wins.
      set_cfg(32'h0500_0000, 32'h1, 12'd4, 16'd3, 24'd5);
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      i_start = 1'b0;
      i_abort = 1'b0;
      chk("start_abort_busy", o_busy, 0);
      chk("start_abort_ftw", o_DDS_FTW, 32'h0120_0000);
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (o_busy) cnt++;
      end
      chk("start_abort_stays_idle", cnt, 0);

      // Asynchronous reset while settling.
      set_cfg(32'h0100_0000, 32'h0010_0000, 12'd4, 16'd3, 24'd5);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      chk("rstmid_pre_busy", o_busy, 1);
      chk("rstmid_pre_meas_en", o_meas_en, 0);
      rst = 1'b0;
      #1;
      chk("rstmid_ftw", o_DDS_FTW, 0);
      chk("rstmid_idx", o_point_idx, 0);
      chk("rstmid_busy", o_busy, 0);
      tick();
      rst = 1'b1;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (o_done || o_point_done || o_busy || o_meas_en) cnt++;
      end
      chk("rstmid_no_pulses", cnt, 0);

`ifdef DDS_SWEEP_LOOP_EN
      begin
         int d0, d1, d2, nd;
         logic [31:0] f7, f13;
         d0 = -1; d1 = -1; d2 = -1; nd = 0; f7 = '0; f13 = '0;
         set_cfg(32'h0000_1000, 32'h0000_0010, 12'd2, 16'd1, 24'd1);
         i_loop  = 1'b1;
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         i_loop  = 1'b0;
         scramble_cfg();
         for (int c = 1; c <= 19; c++) begin
            if (o_done) begin
               if (nd == 0) d0 = c;
               else if (nd == 1) d1 = c;
               else if (nd == 2) d2 = c;
               nd++;
            end
            if (c == 7) f7 = o_DDS_FTW;
            if (c == 13) f13 = o_DDS_FTW;
            tick();
         end
         chk("loop_done_cnt", nd, 3);
         chk("loop_done0", d0, 6);
         chk("loop_done1", d1, 12);
         chk("loop_done2", d2, 18);
         chk("loop_reload_ftw1", f7, 32'h0000_1000);
         chk("loop_reload_ftw2", f13, 32'h0000_1000);
         chk("loop_busy_c20", o_busy, 1);
         i_abort = 1'b1;
         tick();
         i_abort = 1'b0;
         chk("loop_abort_busy", o_busy, 0);
         cnt = 0;
         for (int c = 0; c < 12; c++) begin
            tick();
            if (o_done || o_busy) cnt++;
         end
         chk("loop_abort_stays_idle", cnt, 0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
